// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: shifter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned DataBits          = 8;
    localparam int unsigned StopBits          = 1;
    localparam int unsigned DefaultClksPerBit = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO for the UART transmitter; used only when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       sysclk,
    input  logic                       sysreset_n,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [7:0]      r_mem [DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PtrW'(1);
            if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with write buffer and sticky overrun flag.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        idle,
    output logic        overrun,
    input  logic        clr_overrun,
    output logic        tx
);

    localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  DataLast = 3'(DataBits - 1);
    localparam logic [2:0]  StopLast = 3'(StopBits - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_port: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end

    tx_state_e        r_state, w_state_next;
    logic [BaudW-1:0] r_baud, w_baud_next;
    logic [2:0]       r_idx, w_idx_next;
    logic [7:0]       r_shreg, w_shreg_next;
    logic             r_tx, w_tx_next;
    logic             r_idle;
    logic             r_overrun;

    logic       w_buf_full, w_buf_empty;
    logic [7:0] w_buf_head;
    logic       w_buf_push, w_buf_pop;
    logic       w_baud_done, w_pop_slot, w_pop, w_accept, w_drop, w_bypass;
    logic [7:0] w_pop_byte;
    logic       w_unused_hi;

    assign w_unused_hi = ^wr_data[15:8];

    assign w_baud_done = (r_baud == '0);
    assign w_pop_slot  = (r_state == StIdle) ||
                         (r_state == StStop && w_baud_done && r_idx == StopLast);
    // An incoming write counts as available so an empty buffer can feed the shifter directly.
    assign w_pop       = w_pop_slot && (!w_buf_empty || wr_en);
    assign w_accept    = wr_en && (!w_buf_full || w_pop);
    assign w_drop      = wr_en && !w_accept;
    assign w_bypass    = w_pop && w_buf_empty;
    assign w_buf_push  = w_accept && !w_bypass;
    assign w_buf_pop   = w_pop && !w_buf_empty;
    assign w_pop_byte  = w_buf_empty ? wr_data[7:0] : w_buf_head;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    logic [CntW-1:0] w_fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .i_push     (w_buf_push),
        .i_data     (wr_data[7:0]),
        .i_pop      (w_buf_pop),
        .o_dout     (w_buf_head),
        .o_count    (w_fifo_count),
        .o_full     (w_buf_full),
        .o_empty    (w_buf_empty)
    );

    a_full_matches_count: assert property (@(posedge sysclk) disable iff (!sysreset_n)
        w_buf_full == (w_fifo_count == CntW'(FIFO_DEPTH)));
`else
    logic [7:0] r_hold;
    logic       r_hold_vld;

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (w_buf_push) begin
            r_hold     <= wr_data[7:0];
            r_hold_vld <= 1'b1;
        end else if (w_buf_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign w_buf_head  = r_hold;
    assign w_buf_full  = r_hold_vld;
    assign w_buf_empty = !r_hold_vld;
`endif

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_idx_next   = r_idx;
        w_shreg_next = r_shreg;
        unique case (r_state)
            StIdle: begin
                if (w_pop) begin
                    w_state_next = StStart;
                    w_baud_next  = BaudReload;
                    w_idx_next   = '0;
                    w_shreg_next = w_pop_byte;
                end
            end
            StStart: begin
                if (w_baud_done) begin
                    w_state_next = StData;
                    w_baud_next  = BaudReload;
                    w_idx_next   = '0;
                end else begin
                    w_baud_next = r_baud - BaudW'(1);
                end
            end
            StData: begin
                if (w_baud_done) begin
                    w_baud_next = BaudReload;
                    if (r_idx == DataLast) begin
                        w_state_next = StStop;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud - BaudW'(1);
                end
            end
            StStop: begin
                if (w_baud_done && r_idx == StopLast) begin
                    w_idx_next = '0;
                    if (w_pop) begin
                        w_state_next = StStart;
                        w_baud_next  = BaudReload;
                        w_shreg_next = w_pop_byte;
                    end else begin
                        w_state_next = StIdle;
                        w_baud_next  = '0;
                    end
                end else if (w_baud_done) begin
                    w_idx_next  = r_idx + 3'd1;
                    w_baud_next = BaudReload;
                end else begin
                    w_baud_next = r_baud - BaudW'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Line level follows the current state, giving one register stage between pop and line.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            StStart: w_tx_next = 1'b0;
            StData:  w_tx_next = r_shreg[r_idx];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_state   <= StIdle;
            r_baud    <= '0;
            r_idx     <= '0;
            r_shreg   <= '0;
            r_tx      <= 1'b1;
            r_idle    <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_shreg <= w_shreg_next;
            r_tx    <= w_tx_next;
            r_idle  <= w_buf_empty && (r_state == StIdle);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign tx      = r_tx;
    assign full    = w_buf_full;
    assign idle    = r_idle;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port at CLKS_PER_BIT=4; adapts buffer depth to UART_TX_FIFO_EN.
module tb_uart_tx_port;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int FRAME = 10 * CPB;
    localparam int NB    = (DEPTH >= 2) ? 3 : 2;
    localparam int NQ    = (DEPTH >= 2) ? 2 : 1;

    logic        sysclk      = 1'b0;
    logic        sysreset_n  = 1'b0;
    logic        wr_en       = 1'b0;
    logic [15:0] wr_data     = '0;
    logic        clr_overrun = 1'b0;
    logic        full, idle, overrun, tx;

    uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .sysclk      (sysclk),
        .sysreset_n  (sysreset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .idle        (idle),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .tx          (tx)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frame_cnt = 0;
    bit         track_full = 0;
    bit         full_seen  = 0;

    always @(negedge sysclk) if (track_full && full === 1'b1) full_seen = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pop_start();
        if (start_q.size() == 0) return -1000;
        return start_q.pop_front();
    endfunction

    // Receiver: every sample of every bit must match, and the byte must match the queue head.
    initial begin : monitor
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        int         t0;
        logic [7:0] e;
        forever begin
            @(negedge sysclk);
            if (sysreset_n === 1'b1 && tx === 1'b0) begin
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                t0      = cyc;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge sysclk);
                    if (sysreset_n !== 1'b1) aborted = 1'b1;
                    if (i % CPB == 0) bits[i / CPB] = tx;
                    else if (tx !== bits[i / CPB]) stable = 1'b0;
                end
                if (!aborted) begin
                    frame_cnt++;
                    start_q.push_back(t0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_frame: got byte 0x%0h, want no frame", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame{stable,stop,data}", {22'd0, stable, bits[9], bits[8:1]},
                              {22'd0, 1'b1, 1'b1, e});
                    end
                end
            end
        end
    end

    task automatic write(input logic [15:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d[7:0]);
        @(posedge sysclk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic goto_neg(input int c);
        do @(negedge sysclk); while (cyc < c);
    endtask

    task automatic goto_drive(input int c);
        while (cyc < c) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || idle !== 1'b1) && n < 3000) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
        $fatal(1);
    end

    initial begin : stimulus
        int t, s, prev, fc;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_idle", idle, 1);
        check("reset_full", full, 0);
        check("reset_overrun", overrun, 0);
        sysreset_n = 1'b1;
        @(posedge sysclk);
        #1;

        // Single byte, upper write bits zero.
        start_q.delete();
        t = cyc;
        write(16'h0041, 1);
        goto_neg(t + 1);
        check("tx_high_before_start", tx, 1);
        goto_neg(t + 2);
        check("tx_start_at_T+2", tx, 0);
        goto_neg(t + 41);
        check("idle_low_at_T+41", idle, 0);
        goto_neg(t + 42);
        check("idle_high_at_T+42", idle, 1);
        check("single_start_latency", pop_start() - t, 2);
        @(posedge sysclk);
        #1;

        // Back-to-back writes; upper data bits must be ignored.
        start_q.delete();
        full_seen  = 0;
        track_full = 1;
        t = cyc;
        write(16'hAB31, 1);
        write(16'hCD32, 1);
        if (NB > 2) write(16'hEF33, 1);
        wait_drain("b2b_drain");
        track_full = 0;
        prev = pop_start();
        check("b2b_first_start", prev - t, 2);
        for (int i = 1; i < NB; i++) begin
            s = pop_start();
            check("b2b_frame_gap", s - prev, FRAME);
            prev = s;
        end
`ifdef UART_TX_FIFO_EN
        check("b2b_full_never", full_seen, 0);
`endif

        // Overrun: shifter plus DEPTH entries accepted, next write dropped.
        for (int i = 0; i <= DEPTH; i++) write(16'h0061 + 16'(i), 1);
        check("ovr_full_after_fill", full, 1);
        check("ovr_clear_before_drop", overrun, 0);
        write(16'h0061 + 16'(DEPTH + 1), 0);
        check("ovr_set_on_drop", overrun, 1);
        check("ovr_full_after_drop", full, 1);
        wr_en       = 1'b1;
        wr_data     = 16'h007E;
        clr_overrun = 1'b1;
        @(posedge sysclk);
        #1;
        wr_en       = 1'b0;
        clr_overrun = 1'b0;
        check("ovr_drop_beats_clear", overrun, 1);
        clr_overrun = 1'b1;
        @(posedge sysclk);
        #1;
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);
        wait_drain("ovr_drain");

        // Write while full in the exact cycle of the STOP-to-START pop.
        start_q.delete();
        t = cyc;
        for (int i = 0; i <= DEPTH; i++) write(16'h0070 + 16'(i), 1);
        goto_drive(t + 40);
        check("coll_full_before", full, 1);
        write(16'h007F, 1);
        check("coll_overrun_clear", overrun, 0);
        check("coll_full_kept", full, 1);
        wait_drain("coll_drain");
        prev = pop_start();
        s    = pop_start();
        check("coll_second_start_gap", s - prev, FRAME);

        // Reset during data bit 3 with bytes queued.
        t = cyc;
        for (int i = 0; i <= NQ; i++) write(16'h0050 + 16'(i), 1);
        goto_drive(t + 18);
        sysreset_n = 1'b0;
        exp_q.delete();
        goto_neg(t + 19);
        check("rst_tx_high", tx, 1);
        check("rst_idle", idle, 1);
        check("rst_full_clear", full, 0);
        @(posedge sysclk);
        #1;
        sysreset_n = 1'b1;
        fc = frame_cnt;
        repeat (100) @(posedge sysclk);
        #1;
        check("rst_no_more_frames", frame_cnt, fc);
        check("rst_idle_after", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
